// File: rtl/cp0_int_source_pkg.sv
// rtl/cp0_int_source_pkg.sv - CP0 register numbers and Cause field positions shared by the interrupt path
package cp0_int_source_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;

  localparam int IP_SW_LO = 8;
  localparam int IP_SW_HI = 9;

  localparam int TIMER_IP = 7;

endpackage

// File: rtl/cp0_int_source_int_sync.sv
// rtl/cp0_int_source_int_sync.sv - multi-flop synchronizer for one asynchronous level input
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the raw level through the flop chain; oldest sample is the output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/cp0_int_source.sv
// rtl/cp0_int_source.sv - Cause.IP pending bits and Count/Compare timer for the commit stage
module cp0_int_source
  import cp0_int_source_pkg::*;
#(
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  ext_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [2:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic [7:0]  cause_ip,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [5:0]  ext_s;
  logic [1:0]  sw_ip;
  logic [3:0]  div;
  logic        inc;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_cause;
  logic [31:0] count_inc;

  for (genvar i = 0; i < 6; i++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (ext_int[i]),
      .q      (ext_s[i])
    );
  end

  // decode the mtc0 target; only select 0 of our three registers is acted on
  always_comb begin
    wr_count   = 1'b0;
    wr_compare = 1'b0;
    wr_cause   = 1'b0;
    if (cp0_we && (cp0_sel == 3'd0)) begin
      wr_count   = (cp0_addr == CP0_COUNT);
      wr_compare = (cp0_addr == CP0_COMPARE);
      wr_cause   = (cp0_addr == CP0_CAUSE);
    end
  end

  assign inc       = (div == DIV_LAST);
  assign count_inc = count + 32'd1;

  // prescaler; a Count load restarts the period so the next tick is a full COUNT_DIV away
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div <= '0;
    end else if (wr_count || inc) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // Count: software load beats the tick in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (wr_count) begin
      count <= cp0_wdata;
    end else if (inc) begin
      count <= count_inc;
    end
  end

  // Compare and the sticky match flag; only a real tick can match, a Compare write always clears
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare   <= '0;
      timer_int <= 1'b0;
    end else if (wr_compare) begin
      compare   <= cp0_wdata;
      timer_int <= 1'b0;
    end else if (inc && !wr_count && (count_inc == compare)) begin
      timer_int <= 1'b1;
    end
  end

  // software-requested interrupt bits from Cause.IP[1:0]
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_ip <= '0;
    end else if (wr_cause) begin
      sw_ip <= cp0_wdata[IP_SW_HI:IP_SW_LO];
    end
  end

  assign cause_ip[TIMER_IP]   = ext_s[5] | timer_int;
  assign cause_ip[6:2]        = ext_s[4:0];
  assign cause_ip[1:0]        = sw_ip;

endmodule
